// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver with valid/ack handshake and frame/overrun error pulses.
// Optional 8E1 framing with a parity_err pulse when UART_RX_PARITY_EN is defined.
module uart_rx_cmd #(
   parameter int CLK_FREQ = 81_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       rxp,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ack,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);

   localparam int CPB  = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int HALF = CPB / 2;
   localparam logic [9:0] CPB_LAST  = 10'(CPB - 1);
   localparam logic [9:0] HALF_LAST = 10'(HALF - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t     state;
   logic [9:0] cnt;
   logic [2:0] bit_idx;
   logic [7:0] shift;
   logic       rs_meta;
   logic       rs;
   logic       rs_d;
   logic       commit_pend;
   logic       ferr_pend;
`ifdef UART_RX_PARITY_EN
   logic       perr_pend;
`endif

   // rs_d trails rs by one clock so a falling edge is visible in IDLE.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rs_meta <= 1'b1;
         rs      <= 1'b1;
         rs_d    <= 1'b1;
      end else begin
         rs_meta <= rxp;
         rs      <= rs_meta;
         rs_d    <= rs;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         commit_pend <= 1'b0;
         ferr_pend   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_pend   <= 1'b0;
`endif
      end else begin
         commit_pend <= 1'b0;
         ferr_pend   <= 1'b0;
         case (state)
            IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (rs_d && !rs) begin
                  state <= START;
               end
            end
            START: begin
               if (cnt == HALF_LAST) begin
                  cnt   <= '0;
                  state <= rs ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
            DATA: begin
               if (cnt == CPB_LAST) begin
                  cnt            <= '0;
                  shift[bit_idx] <= rs;
                  bit_idx        <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == CPB_LAST) begin
                  cnt       <= '0;
                  perr_pend <= rs ^ (^shift);
                  state     <= STOP;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
`endif
            STOP: begin
               if (cnt == CPB_LAST) begin
                  cnt         <= '0;
                  commit_pend <= rs;
                  ferr_pend   <= !rs;
                  state       <= IDLE;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   // A commit beats a simultaneous ack; overrun reflects valid before this edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= ferr_pend;
         overrun   <= 1'b0;
         if (commit_pend) begin
            data    <= shift;
            valid   <= 1'b1;
            overrun <= valid;
         end else if (ack) begin
            valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity error lands with the valid rise of the same byte.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         parity_err <= 1'b0;
      end else begin
         parity_err <= commit_pend & perr_pend;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed self-checking bench for uart_rx_cmd at CPB=10, HALF=5.
// Define UART_RX_PARITY_EN to exercise the 8E1 build.
module tb_uart_rx_cmd;

   localparam int CPB  = 10;
   localparam int HALF = 5;
`ifdef UART_RX_PARITY_EN
   localparam int EXP_LAT = 3 + HALF + 10 * CPB;
`else
   localparam int EXP_LAT = 3 + HALF + 9 * CPB;
`endif

   logic       clk;
   logic       resetn;
   logic       rxp;
   logic [7:0] data;
   logic       valid;
   logic       ack;
   logic       busy;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int pe_cnt = 0;
   logic valid_q = 1'b0;
   logic mid_busy = 1'b0;
   time  start_t = 0;
   time  rise_t = 0;
   int   lat;

   uart_rx_cmd #(
      .CLK_FREQ(1_000_000),
      .BAUD    (100_000)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .rxp       (rxp),
      .data      (data),
      .valid     (valid),
      .ack       (ack),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun),
      .parity_err(parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters and valid-rise timestamp, sampled away from the active edge.
   always @(negedge clk) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (parity_err) pe_cnt++;
      if (valid && !valid_q) rise_t = $time;
      valid_q = valid;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Sends one frame starting at a negedge; do_ack pulses ack in the first start-bit cycle.
   task automatic applyStimulus(input logic [7:0] b, input logic stop_bit,
                                input logic par_flip, input logic do_ack);
      rxp     = 1'b0;
      ack     = do_ack;
      start_t = $time;
      @(negedge clk);
      ack = 1'b0;
      repeat (CPB - 1) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxp = b[i];
         repeat (CPB) @(negedge clk);
         if (i == 3) mid_busy = busy;
      end
`ifdef UART_RX_PARITY_EN
      rxp = (^b) ^ par_flip;
      repeat (CPB) @(negedge clk);
`else
      if (par_flip) rxp = 1'b1;
`endif
      rxp = stop_bit;
      repeat (CPB) @(negedge clk);
   endtask

   initial begin
      resetn = 1'b0;
      rxp    = 1'b1;
      ack    = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_data", {24'd0, data}, 32'h0);
      checkOutput("rst_valid", {31'd0, valid}, 32'h0);
      checkOutput("rst_busy", {31'd0, busy}, 32'h0);
      checkOutput("rst_frame_err", {31'd0, frame_err}, 32'h0);
      checkOutput("rst_overrun", {31'd0, overrun}, 32'h0);
      checkOutput("rst_parity_err", {31'd0, parity_err}, 32'h0);
      resetn = 1'b1;
      repeat (5) @(negedge clk);

      $display("[TB] single frame 0x55");
      applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
      lat = int'((rise_t - start_t) / 10);
      checkOutput("t1_busy_mid", {31'd0, mid_busy}, 32'h1);
      checkOutput("t1_latency_ok", {31'd0, (lat >= EXP_LAT - 1) && (lat <= EXP_LAT + 1)}, 32'h1);
      checkOutput("t1_valid", {31'd0, valid}, 32'h1);
      checkOutput("t1_data", {24'd0, data}, 32'h55);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checkOutput("t1_valid_after_ack", {31'd0, valid}, 32'h0);
      repeat (5) @(negedge clk);

      $display("[TB] back-to-back 0xA5, 0x3C");
      applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
      checkOutput("t2_data_a5", {24'd0, data}, 32'hA5);
      checkOutput("t2_valid_a5", {31'd0, valid}, 32'h1);
      applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1);
      checkOutput("t2_data_3c", {24'd0, data}, 32'h3C);
      checkOutput("t2_valid_3c", {31'd0, valid}, 32'h1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      checkOutput("t2_valid_after_ack", {31'd0, valid}, 32'h0);
      checkOutput("t2_no_overrun", ov_cnt, 32'd0);
      checkOutput("t2_no_frame_err", fe_cnt, 32'd0);
      repeat (5) @(negedge clk);

      $display("[TB] 3-cycle glitch");
      rxp = 1'b0;
      repeat (3) @(negedge clk);
      rxp = 1'b1;
      checkOutput("t3_busy_during", {31'd0, busy}, 32'h1);
      repeat (HALF + 1) @(negedge clk);
      checkOutput("t3_busy_ended", {31'd0, busy}, 32'h0);
      repeat (30) @(negedge clk);
      checkOutput("t3_valid", {31'd0, valid}, 32'h0);
      checkOutput("t3_busy_idle", {31'd0, busy}, 32'h0);

      $display("[TB] bad stop bit then break");
      applyStimulus(8'hF0, 1'b0, 1'b0, 1'b0);
      repeat (40) @(negedge clk);
      checkOutput("t4_busy_in_break", {31'd0, busy}, 32'h0);
      rxp = 1'b1;
      repeat (150) @(negedge clk);
      checkOutput("t4_frame_err_once", fe_cnt, 32'd1);
      checkOutput("t4_valid", {31'd0, valid}, 32'h0);
      checkOutput("t4_no_overrun", ov_cnt, 32'd0);

      $display("[TB] overrun 0x11, 0x22");
      applyStimulus(8'h11, 1'b1, 1'b0, 1'b0);
      checkOutput("t5_data_11", {24'd0, data}, 32'h11);
      checkOutput("t5_no_overrun_yet", ov_cnt, 32'd0);
      applyStimulus(8'h22, 1'b1, 1'b0, 1'b0);
      checkOutput("t5_overrun_once", ov_cnt, 32'd1);
      checkOutput("t5_data_22", {24'd0, data}, 32'h22);
      checkOutput("t5_valid", {31'd0, valid}, 32'h1);

`ifdef UART_RX_PARITY_EN
      $display("[TB] parity 0x07");
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      applyStimulus(8'h07, 1'b1, 1'b1, 1'b0);
      checkOutput("t6_bad_par_data", {24'd0, data}, 32'h07);
      checkOutput("t6_bad_par_valid", {31'd0, valid}, 32'h1);
      checkOutput("t6_parity_err_once", pe_cnt, 32'd1);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      applyStimulus(8'h07, 1'b1, 1'b0, 1'b0);
      checkOutput("t6_good_par_valid", {31'd0, valid}, 32'h1);
      checkOutput("t6_no_new_parity_err", pe_cnt, 32'd1);
`else
      checkOutput("t6_parity_err_never", pe_cnt, 32'd0);
`endif

      $display("[TB] reset mid-frame");
      rxp = 1'b0;
      repeat (CPB + 3 * CPB) @(negedge clk);
      checkOutput("t7_busy_before_rst", {31'd0, busy}, 32'h1);
      resetn = 1'b0;
      #1;
      checkOutput("t7_rst_data", {24'd0, data}, 32'h0);
      checkOutput("t7_rst_valid", {31'd0, valid}, 32'h0);
      checkOutput("t7_rst_busy", {31'd0, busy}, 32'h0);
      checkOutput("t7_rst_errs", {29'd0, frame_err, overrun, parity_err}, 32'h0);
      rxp = 1'b1;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      repeat (5) @(negedge clk);
      applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0);
      checkOutput("t7_clean_data", {24'd0, data}, 32'h5A);
      checkOutput("t7_clean_valid", {31'd0, valid}, 32'h1);
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
